cardinal_nic: RTL
=================

CARDINAL_NIC -- requirements
Module: cardinal_nic

Interface
REQ-001 Parameter DATA_W, default 64, width of the packet and processor data buses.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 addr  input  2 [0:1]  register select from processor: 00 ICB, 01 ICB status, 10 OCB, 11 OCB status.
REQ-005 d_in  input  DATA_W [0:63]  processor write data.
REQ-006 d_out  output  DATA_W [0:63]  registered processor read data.
REQ-007 nicEn  input  1  processor access strobe.
REQ-008 nicWrEn  input  1  1 = write, 0 = read; valid only with nicEn.
REQ-009 net_si  input  1  router-to-NIC send request.
REQ-010 net_ri  output  1  NIC-to-router ready; NIC can accept a packet.
REQ-011 net_di  input  DATA_W [0:63]  router-to-NIC packet.
REQ-012 net_so  output  1  NIC-to-router send strobe.
REQ-013 net_ro  input  1  router ready to accept an injected packet.
REQ-014 net_do  output  DATA_W [0:63]  NIC-to-router packet.
REQ-015 net_polarity  input  1  router virtual-channel phase; bit [0] of each packet is its VC.

Function
REQ-016 Input channel buffer (ICB): one DATA_W register plus flag icb_full.
REQ-017 net_ri = ~icb_full (combinational).
REQ-018 Receive: net_si & ~icb_full at an edge -> ICB <= net_di and icb_full <= 1. net_si while full is ignored with no state change.
REQ-019 Output channel buffer (OCB): one DATA_W register plus flag ocb_full.
REQ-020 Processor write: nicEn & nicWrEn & addr==10 & ~ocb_full at an edge -> OCB <= d_in and ocb_full <= 1. A write while full is dropped silently.
REQ-021 Writes to addresses 00, 01 and 11 have no effect.
REQ-022 Inject: net_so = ocb_full & net_ro & (OCB[0] == net_polarity) (combinational). net_do = OCB at all times.
REQ-023 ocb_full clears at the edge where net_so=1.
REQ-024 Processor read: nicEn & ~nicWrEn at an edge -> d_out <= selected value. Result is valid the cycle after the strobe (1-cycle latency, matching the processor's execute-stage capture).
REQ-025 Read data by address:
  - 00 -> ICB contents.
  - 01 -> {63'b0, icb_full}.
  - 10 -> OCB contents.
  - 11 -> {63'b0, ocb_full}.
  - Status bits are the values before the edge.
REQ-026 A read of 00 while icb_full=1 clears icb_full at the same edge.
REQ-027 A read of 00 while empty returns the stale ICB and changes no state.
REQ-028 d_out holds its last value when no read strobe is present.
REQ-029 ICB boundary: a receive cannot coincide with an ICB drain, because net_ri=0 while full. A drain at edge N allows a receive at edge N+1 at the earliest.
REQ-030 OCB boundary: if an inject (net_so=1) and a processor write occur in the same cycle, the inject completes and the write is dropped, since ocb_full was 1 before the edge.
REQ-031 The ICB path and the OCB path operate independently; a processor access and a network transfer in the same cycle both take effect.

Reset
REQ-032 While reset=1 at an edge: icb_full<=0, ocb_full<=0, d_out<=0, ICB<=0, OCB<=0.
REQ-033 Resulting outputs during and after reset: net_ri=1, net_so=0, net_do=0.
REQ-034 Reset dominates all concurrent receive, write, read and inject events. A packet in flight at reset is discarded.

Structure
REQ-035 Shared package cardinal_pkg holds:
  - address constants NIC_ICB=2'b00, NIC_ICB_ST=2'b01, NIC_OCB=2'b10, NIC_OCB_ST=2'b11;
  - DATA_W default.
REQ-036 A single sub-module, cardinal_nic_buf (DATA_W register + full flag, with load/drain ports), is instantiated twice: once for the ICB, once for the OCB.

Verification
REQ-037 Write 64'h0123_4567_89AB_CDEE to 10 with net_ro=1, net_polarity=0 -> next cycle net_so=1, net_do=64'h0123_4567_89AB_CDEE; ocb_full=0 after that edge.
REQ-038 Write 64'h8000_0000_0000_0001 (VC=1) with net_polarity=0 -> net_so stays 0; toggle net_polarity=1 -> net_so=1 for exactly one cycle.
REQ-039 Receive:
  - Router drives net_si=1, net_di=64'hDEAD_BEEF_0000_0001 -> net_ri=0.
  - Read 01 -> d_out=1 next cycle.
  - Read 00 -> d_out=64'hDEAD_BEEF_0000_0001.
  - Then net_ri=1.
REQ-040 Fill the OCB with net_ro=0, then write 64'h5 to 10 -> the write is dropped: read 10 returns the first value, read 11 returns 1.
REQ-041 Fill the ICB, then hold net_si=1 with a new value for 3 cycles -> ICB unchanged and net_ri=0 throughout.
REQ-042 Assert reset with both buffers full -> next cycle net_ri=1, net_so=0, d_out=0, read 01 and read 11 both return 0.

Source files
------------

// File: rtl/cardinal_pkg.sv
// Shared constants for the Cardinal network interface controller.
package cardinal_pkg;

    // Default width of the processor and packet data buses.
    localparam int unsigned NIC_DATA_W = 64;

    // Processor-visible register map.
    localparam logic [1:0] NIC_ICB    = 2'b00;
    localparam logic [1:0] NIC_ICB_ST = 2'b01;
    localparam logic [1:0] NIC_OCB    = 2'b10;
    localparam logic [1:0] NIC_OCB_ST = 2'b11;

endpackage

// File: rtl/cardinal_nic_buf.sv
// Single-entry channel buffer: one data register plus a full flag.
// A load is accepted only while empty; a drain only empties a full buffer.
module cardinal_nic_buf #(
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_drain,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full
);

    logic [DATA_W-1:0] r_data;
    logic              r_full;

    // Capture on load when empty, release on drain when full; reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (i_load && !r_full) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end else if (i_drain && r_full) begin
            r_full <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule

// File: rtl/cardinal_nic.sv
// Cardinal NIC: processor-mapped input/output channel buffers between a core and a router.
// The ICB holds one packet received from the router; the OCB holds one packet to inject.
module cardinal_nic
    import cardinal_pkg::*;
#(
    parameter int unsigned DATA_W = NIC_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    // Processor side
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    input  logic              nicEn,
    input  logic              nicWrEn,
    // Router side
    input  logic              net_si,
    output logic              net_ri,
    input  logic [DATA_W-1:0] net_di,
    output logic              net_so,
    input  logic              net_ro,
    output logic [DATA_W-1:0] net_do,
    input  logic              net_polarity
);

    logic [DATA_W-1:0] w_icb_data;
    logic              w_icb_full;
    logic              w_icb_load;
    logic              w_icb_drain;

    logic [DATA_W-1:0] w_ocb_data;
    logic              w_ocb_full;
    logic              w_ocb_load;
    logic              w_ocb_drain;

    logic              w_rd;
    logic              w_wr;
    logic              w_vc_match;
    logic [DATA_W-1:0] w_rd_data;
    logic [DATA_W-1:0] r_d_out;

    assign w_rd = nicEn && !nicWrEn;
    assign w_wr = nicEn && nicWrEn;

    // Receive path: the router may only send while the ICB is empty.
    assign net_ri      = !w_icb_full;
    assign w_icb_load  = net_si && !w_icb_full;
    // Reading the ICB data register consumes the packet.
    assign w_icb_drain = w_rd && (addr == NIC_ICB) && w_icb_full;

    // Inject path: a packet leaves only in the router phase that matches its VC (bit 0).
    assign w_ocb_load  = w_wr && (addr == NIC_OCB) && !w_ocb_full;
    assign w_vc_match  = (w_ocb_data[0] == net_polarity);
    assign net_so      = w_ocb_full && net_ro && w_vc_match;
    assign w_ocb_drain = net_so;
    assign net_do      = w_ocb_data;

    cardinal_nic_buf #(
        .DATA_W (DATA_W)
    ) u_icb (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_icb_load),
        .i_data  (net_di),
        .i_drain (w_icb_drain),
        .o_data  (w_icb_data),
        .o_full  (w_icb_full)
    );

    cardinal_nic_buf #(
        .DATA_W (DATA_W)
    ) u_ocb (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_ocb_load),
        .i_data  (d_in),
        .i_drain (w_ocb_drain),
        .o_data  (w_ocb_data),
        .o_full  (w_ocb_full)
    );

    // Select read data from the register map; status words carry the flag in bit 0.
    always_comb begin
        w_rd_data = '0;
        case (addr)
            NIC_ICB:    w_rd_data = w_icb_data;
            NIC_ICB_ST: w_rd_data = {{(DATA_W-1){1'b0}}, w_icb_full};
            NIC_OCB:    w_rd_data = w_ocb_data;
            NIC_OCB_ST: w_rd_data = {{(DATA_W-1){1'b0}}, w_ocb_full};
            default:    w_rd_data = '0;
        endcase
    end

    // Register read data one cycle after the strobe; hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_d_out <= '0;
        end else if (w_rd) begin
            r_d_out <= w_rd_data;
        end
    end

    assign d_out = r_d_out;

endmodule
